// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, blank
// pattern and a polarity helper used by the decoder and the top level.
package sseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high {g,f,e,d,c,b,a} glyphs, entry 15 (F) first down to entry 0.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_polarize(input logic [6:0] seg_ah,
                                                input logic       active_high);
        return active_high ? seg_ah : ~seg_ah;
    endfunction

endpackage

// File: rtl/sseg_scan_driver_digit_decode.sv
// Combinational digit decoder: one 4-bit code to seven pin-level segments,
// with hex/blank control and output polarity applied.
module sseg_digit_decode
    import sseg_pkg::*;
#(
    parameter int SEG_POLARITY = 1
) (
    input  logic [3:0] code,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] seg_ah;

    always_comb begin
        seg_ah = SEG_BLANK;
        // Codes above 9 only have a glyph when hex display is enabled.
        if (!blank && (hex_mode || code <= 4'd9)) begin
            seg_ah = SEG_LUT[code];
        end
        seg = seg_polarize(seg_ah, SEG_POLARITY != 0);
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with guard time, leading-zero
// blanking and frame-aligned (tear-free) display updates.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SEG_POLARITY  = 1,
    parameter int DIG_POLARITY  = 0,
    parameter int REFRESH_DIV   = 50000,
    parameter int GUARD_CYCLES  = 2,
    parameter int HEX_MODE      = 0,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              sseg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]         GUARD_END  = PW'(GUARD_CYCLES);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic                  SEG_AH     = (SEG_POLARITY != 0);
    localparam logic [6:0]            SEG_UNLIT  = seg_polarize(SEG_BLANK, SEG_AH);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF    = (DIG_POLARITY != 0) ? '0 : '1;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [6:0]            sseg_q, sseg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_end;
    logic                  wrap;
    logic                  zero_above;
    logic [NUM_DIGITS-1:0] lead_blank;
    logic [3:0]            cur_code;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [6:0]            cur_seg;
    logic [NUM_DIGITS-1:0] dig_act;

    assign slot_end = en && (presc_q == PRESC_LAST);
    assign wrap     = slot_end && (idx_q == IDX_LAST);

    // Scan timing: prescaler and digit index, both held at zero while disabled.
    always_comb begin
        presc_d = '0;
        idx_d   = '0;
        if (en) begin
            presc_d = slot_end ? '0 : presc_q + 1'b1;
            idx_d   = idx_q;
            if (slot_end) begin
                idx_d = wrap ? '0 : idx_q + 1'b1;
            end
        end
    end

    // Loads land in pending and move to display only on the frame wrap, so a
    // frame never mixes old and new digits. A load on the wrap goes straight in.
    always_comb begin
        pend_d     = pend_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        disp_d     = disp_q;
        disp_dp_d  = disp_dp_q;
        if (wrap) begin
            if (load) begin
                disp_d    = digits_in;
                disp_dp_d = dp_in;
            end else if (pend_vld_q) begin
                disp_d    = pend_q;
                disp_dp_d = pend_dp_q;
            end
            pend_vld_d = 1'b0;
        end else if (load) begin
            pend_d     = digits_in;
            pend_dp_d  = dp_in;
            pend_vld_d = 1'b1;
        end
    end

    // Leading-blank mask: walk from the MSD down while every code seen is zero.
    always_comb begin
        zero_above = 1'b1;
        lead_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above    = zero_above && (disp_q[4*k +: 4] == 4'd0);
            lead_blank[k] = (BLANK_LEADING != 0) && (k != 0) && zero_above;
        end
        cur_code  = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_code  = disp_q[4*k +: 4];
                cur_dp    = disp_dp_q[k];
                cur_blank = lead_blank[k];
            end
        end
    end

    sseg_digit_decode #(
        .SEG_POLARITY(SEG_POLARITY)
    ) u_decode (
        .code    (cur_code),
        .hex_mode(HEX_MODE != 0),
        .blank   (cur_blank),
        .seg     (cur_seg)
    );

    // Segments stay valid for the whole slot; only the digit enable honours the guard.
    always_comb begin
        dig_act = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            dig_act[k] = en && (presc_q >= GUARD_END) && (idx_q == IW'(k));
        end
        dig_sel_d    = (DIG_POLARITY != 0) ? dig_act : ~dig_act;
        sseg_d       = en ? cur_seg : SEG_UNLIT;
        dp_d         = (en && cur_dp) ? SEG_AH : ~SEG_AH;
        frame_done_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_vld_q   <= 1'b0;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            sseg_q       <= SEG_UNLIT;
            dp_q         <= ~SEG_AH;
            dig_sel_q    <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_vld_q   <= pend_vld_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            sseg_q       <= sseg_d;
            dp_q         <= dp_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sseg_out   = sseg_q;
    assign dp_out     = dp_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: two differently configured instances share one
// stimulus stream; a frame-position reference model feeds an expected queue.
module tb_sseg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int GUARD = 1;
    localparam int FRAME = N * DIV;
    localparam int EW    = 26;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        en        = 1'b0;
    logic        load      = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in     = '0;

    logic [6:0] sseg_a, sseg_b;
    logic       dp_a, dp_b;
    logic [3:0] dig_a, dig_b;
    logic       fd_a, fd_b;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];

    // Reference model state: cycle position within the frame and shown/next words.
    int          m_t       = 0;
    logic [15:0] m_word    = '0;
    logic [3:0]  m_dp      = '0;
    logic [15:0] m_new     = '0;
    logic [3:0]  m_new_dp  = '0;
    bit          m_has_new = 1'b0;

    // Instance A: hex on, leading blanking, lit-high segments, active-low digits.
    sseg_scan_driver #(
        .NUM_DIGITS(N), .SEG_POLARITY(1), .DIG_POLARITY(0), .REFRESH_DIV(DIV),
        .GUARD_CYCLES(GUARD), .HEX_MODE(1), .BLANK_LEADING(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .sseg_out(sseg_a), .dp_out(dp_a), .dig_sel(dig_a),
        .frame_done(fd_a)
    );

    // Instance B: hex off, no blanking, lit-low segments, active-high digits.
    sseg_scan_driver #(
        .NUM_DIGITS(N), .SEG_POLARITY(0), .DIG_POLARITY(1), .REFRESH_DIV(DIV),
        .GUARD_CYCLES(GUARD), .HEX_MODE(0), .BLANK_LEADING(0)
    ) u_alt (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .sseg_out(sseg_b), .dp_out(dp_b), .dig_sel(dig_b),
        .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Expected pins one cycle after an edge at frame position t.
    function automatic logic [12:0] ref_out(input bit on, input int t, input logic [15:0] word,
                                            input logic [3:0] dps, input bit hex, input bit blank_lead,
                                            input bit seg_pol, input bit dig_pol);
        int         slot;
        int         phase;
        logic [3:0] code;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] act;
        logic       fd;
        slot  = (t / DIV) % N;
        phase = t % DIV;
        seg   = '0;
        dp    = 1'b0;
        act   = '0;
        fd    = 1'b0;
        if (on) begin
            code = 4'((word >> (4 * slot)) & 16'h000F);
            seg  = (code <= 4'd9 || hex) ? glyph(code) : 7'h00;
            if (blank_lead && slot > 0 && (word >> (4 * slot)) == 16'h0000) seg = 7'h00;
            dp   = dps[slot];
            if (phase >= GUARD) act = 4'(1 << slot);
            fd   = (t == FRAME - 1);
        end
        if (!seg_pol) begin
            seg = ~seg;
            dp  = ~dp;
        end
        if (!dig_pol) act = ~act;
        return {seg, dp, act, fd};
    endfunction

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    task automatic chk_reset();
        chk("rst_seg_a", sseg_a, 7'h00);
        chk("rst_dp_a", 7'(dp_a), 7'h00);
        chk("rst_dig_a", 7'(dig_a), 7'h0F);
        chk("rst_fd_a", 7'(fd_a), 7'h00);
        chk("rst_seg_b", sseg_b, 7'h7F);
        chk("rst_dp_b", 7'(dp_b), 7'h01);
        chk("rst_dig_b", 7'(dig_b), 7'h00);
        chk("rst_fd_b", 7'(fd_b), 7'h00);
    endtask

    // Reference model: pushes the expected pins for every edge out of reset.
    initial begin
        bit frame_end;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_t       = 0;
                m_word    = '0;
                m_dp      = '0;
                m_new     = '0;
                m_new_dp  = '0;
                m_has_new = 1'b0;
                exp_q.delete();
            end else begin
                exp_q.push_back({ref_out(en, m_t, m_word, m_dp, 1'b1, 1'b1, 1'b1, 1'b0),
                                 ref_out(en, m_t, m_word, m_dp, 1'b0, 1'b0, 1'b0, 1'b1)});
                frame_end = en && (m_t == FRAME - 1);
                if (frame_end) begin
                    if (load) begin
                        m_word = digits_in;
                        m_dp   = dp_in;
                    end else if (m_has_new) begin
                        m_word = m_new;
                        m_dp   = m_new_dp;
                    end
                    m_has_new = 1'b0;
                end else if (load) begin
                    m_new     = digits_in;
                    m_new_dp  = dp_in;
                    m_has_new = 1'b1;
                end
                m_t = en ? (m_t + 1) % FRAME : 0;
            end
        end
    end

    // Monitor: compares the pins on every falling edge against the queue head.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("seg_a", sseg_a, e[25:19]);
                chk("dp_a", 7'(dp_a), 7'(e[18]));
                chk("dig_a", 7'(dig_a), 7'(e[17:14]));
                chk("fd_a", 7'(fd_a), 7'(e[13]));
                chk("seg_b", sseg_b, e[12:6]);
                chk("dp_b", 7'(dp_b), 7'(e[5]));
                chk("dig_b", 7'(dig_b), 7'(e[4:1]));
                chk("fd_b", 7'(fd_b), 7'(e[0]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] w, input logic [3:0] d);
        digits_in = w;
        dp_in     = d;
        load      = 1'b1;
        tick(1);
        load      = 1'b0;
    endtask

    // Returns with the next rising edge being the frame wrap.
    task automatic wait_wrap_next();
        int n;
        n = 0;
        while (!(en && m_t == FRAME - 1)) begin
            if (n >= 4 * FRAME) begin
                checks++;
                errors++;
                $display("FAIL wrap_wait: no frame wrap within %0d cycles", n);
                return;
            end
            tick(1);
            n++;
        end
    endtask

    initial begin
        int          lim;
        logic [15:0] w;

        #8;
        chk_reset();
        #4 rst_n = 1'b1;

        // Basic scan of 1234 with some decimal points.
        en = 1'b1;
        do_load(16'h1234, 4'b0101);
        tick(3 * FRAME);

        // Leading-zero blanking, embedded zero, dp on a blanked digit.
        do_load(16'h0007, 4'b0000);
        tick(2 * FRAME);
        do_load(16'h0507, 4'b1000);
        tick(2 * FRAME);

        // Hex codes.
        do_load(16'hABCD, 4'b0010);
        tick(2 * FRAME);

        // Two loads in one frame, then a load on the wrap cycle.
        wait_wrap_next();
        tick(10);
        do_load(16'h1111, 4'b0000);
        tick(6);
        do_load(16'h2222, 4'b0001);
        tick(2 * FRAME);
        wait_wrap_next();
        do_load(16'h3333, 4'b1111);
        tick(FRAME + 4);

        // Disable mid-slot, load while disabled, re-enable.
        tick(11);
        en = 1'b0;
        tick(5);
        do_load(16'h0456, 4'b0100);
        tick(3);
        en = 1'b1;
        tick(2 * FRAME + 5);

        // Asynchronous reset mid-frame, off the clock edge.
        tick(13);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset();
        #10 rst_n = 1'b1;
        tick(2 * FRAME);
        do_load(16'h0089, 4'b0011);
        tick(2 * FRAME);

        // Randomized enable/load traffic, biased towards leading zeros.
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) begin
                lim = $urandom_range(0, 4);
                w   = 16'($urandom);
                if (lim < 4) w = w & 16'((1 << (4 * lim)) - 1);
                digits_in = w;
                dp_in     = 4'($urandom);
                load      = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick(1);
        end
        load = 1'b0;
        en   = 1'b1;
        tick(2 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
